// File: rtl/seq_pattern_tx_pkg.sv
// ============================================================================
// Module : seq_pattern_tx_pkg
// Brief  : Shared state encodings and default widths for the serial pattern
//          transmitter and its sequence-detector partners.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_pattern_tx_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_pattern_tx_piso_shift_reg.sv
// ============================================================================
// Module : piso_shift_reg
// Brief  : Parallel-in serial-out shift register, shift-left with zero fill,
//          MSB presented as the serial output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_shift_reg #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             sout
);

    logic [PAT_W-1:0] sr;

    // Load wins over shift so a frame reload on the last bit is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[PAT_W-2:0], 1'b0};
        end
    end

    assign sout = sr[PAT_W-1];

endmodule

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// ============================================================================
// Module : seq_pattern_tx
// Brief  : Serial pattern transmitter: sends a latched pattern MSB first,
//          repeat_n+1 times, with an optional idle gap between frames.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    output logic             ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_end,
    output logic             done
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
    localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'(PAT_W - 2);

    state_t           state, state_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic [CNT_W-1:0] frame_cnt, frame_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [PAT_W-1:0] pat_q;
    logic [GAP_W-1:0] gap_q;

    logic             accept;
    logic             ready_n, valid_n, fe_n, done_n;
    logic             sr_load, sr_shift;
    logic [PAT_W-1:0] sr_din;

    // The shift register is cleared whenever SHIFT is left, so its MSB is
    // already 0 on every non-valid cycle and can drive dout directly.
    piso_shift_reg #(
        .PAT_W (PAT_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .sout  (dout)
    );

    assign accept = start && ready && (state == S_IDLE);

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        frame_n  = frame_cnt;
        gap_n    = gap_cnt;
        ready_n  = 1'b0;
        valid_n  = 1'b0;
        fe_n     = 1'b0;
        done_n   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_din   = '0;

        unique case (state)
            S_IDLE: begin
                ready_n = 1'b1;
                if (accept) begin
                    state_n = S_SHIFT;
                    bit_n   = '0;
                    frame_n = repeat_n;
                    gap_n   = '0;
                    sr_load = 1'b1;
                    sr_din  = pattern;
                    valid_n = 1'b1;
                    ready_n = 1'b0;
                end
            end
            S_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    sr_load = 1'b1;
                    if (frame_cnt == '0) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        frame_n = frame_cnt - CNT_W'(1);
                        bit_n   = '0;
                        if (gap_q == '0) begin
                            sr_din  = pat_q;
                            valid_n = 1'b1;
                        end else begin
                            state_n = S_GAP;
                            gap_n   = gap_q;
                        end
                    end
                end else begin
                    sr_shift = 1'b1;
                    bit_n    = bit_cnt + BIT_W'(1);
                    valid_n  = 1'b1;
                    fe_n     = (bit_cnt == PRE_LAST);
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_n = S_SHIFT;
                    gap_n   = '0;
                    sr_load = 1'b1;
                    sr_din  = pat_q;
                    valid_n = 1'b1;
                end else begin
                    gap_n = gap_cnt - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            frame_cnt  <= '0;
            gap_cnt    <= '0;
            pat_q      <= '0;
            gap_q      <= '0;
            ready      <= 1'b1;
            dout_valid <= 1'b0;
            frame_end  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_n;
            frame_cnt  <= frame_n;
            gap_cnt    <= gap_n;
            ready      <= ready_n;
            dout_valid <= valid_n;
            frame_end  <= fe_n;
            done       <= done_n;
            if (accept) begin
                pat_q <= pattern;
                gap_q <= gap;
            end
        end
    end

endmodule

`default_nettype wire
